// File: rtl/adder_arbiter.sv
// Round-robin arbiter/sequencer sharing one carry-select adder between two requesters.
// Optional macro ADDER_CHECK_EN builds a behavioral cross-check that drives the sticky err flag.

module select_carry_adder #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned BLK   = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int unsigned NBLK = WIDTH / BLK;

  logic [NBLK:0] carry;

  assign carry[0] = cin;

  // Each block precomputes both carry-in outcomes; the incoming carry only steers a mux.
  for (genvar i = 0; i < NBLK; i++) begin : g_blk
    logic [BLK:0] s0;
    logic [BLK:0] s1;
    assign s0 = {1'b0, a[i*BLK +: BLK]} + {1'b0, b[i*BLK +: BLK]};
    assign s1 = s0 + (BLK+1)'(1);
    assign sum[i*BLK +: BLK] = carry[i] ? s1[BLK-1:0] : s0[BLK-1:0];
    assign carry[i+1]        = carry[i] ? s1[BLK]     : s0[BLK];
  end

  assign cout = carry[NBLK];
endmodule

module adder_arbiter #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             busy,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q;
  state_t           state_d;
  logic             last_grant_q;
  logic             gid_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic             grant_c;
  logic             accept_c;
  logic             capture_c;
  logic             done_c;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  // Under contention the requester not served last wins; otherwise the lone valid one.
  assign grant_c = (req0_valid && req1_valid) ? ~last_grant_q : ~req0_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept_c   = 1'b0;
    capture_c  = 1'b0;
    done_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready = ~grant_c;
          req1_ready = grant_c;
          accept_c   = 1'b1;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        capture_c = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  select_carry_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (a_q),
    .b    (b_q),
    .cin  (cin_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      cin_q        <= 1'b0;
      gid_q        <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_sum      <= '0;
      rsp_cout     <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      if (accept_c) begin
        a_q          <= grant_c ? req1_a   : req0_a;
        b_q          <= grant_c ? req1_b   : req0_b;
        cin_q        <= grant_c ? req1_cin : req0_cin;
        gid_q        <= grant_c;
        last_grant_q <= grant_c;
      end
      if (capture_c) begin
        rsp_sum    <= add_sum;
        rsp_cout   <= add_cout;
        rsp0_valid <= ~gid_q;
        rsp1_valid <= gid_q;
      end
      if (done_c) begin
        rsp0_valid <= 1'b0;
        rsp1_valid <= 1'b0;
      end
      busy <= (state_d != IDLE);
    end
  end

`ifdef ADDER_CHECK_EN
  logic [WIDTH:0] ref_sum_c;

  assign ref_sum_c = {1'b0, a_q} + {1'b0, b_q} + (WIDTH+1)'(cin_q);

  // Sticky until reset: any disagreement between the shared adder and the reference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                   err <= 1'b0;
    else if (state_q == EXEC && {add_cout, add_sum} != ref_sum_c) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed, table-driven bench for adder_arbiter: single ops, stall, mid-op reset, contention.

module tb_adder_arbiter;
  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_cin = 1'b0, req1_cin = 1'b0;
  logic         rsp0_valid, rsp1_valid;
  logic         rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout, busy, err;

  int n_checks = 0;
  int n_fail   = 0;

  adder_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int           port;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int port, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    if (port == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin; end
    else           begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin; end
  endtask

  // Full handshake for one requester; called at a negedge with the DUT idle.
  task automatic do_op(input vec_t v, input string tag);
    set_req(v.port, v.a, v.b, v.cin);
    #1;
    check({tag, " ready0"}, (W+1)'(req0_ready), (W+1)'(v.port == 0));
    check({tag, " ready1"}, (W+1)'(req1_ready), (W+1)'(v.port == 1));
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    check({tag, " exec busy"}, (W+1)'(busy), (W+1)'(1));
    check({tag, " exec rspv"}, (W+1)'({rsp1_valid, rsp0_valid}), (W+1)'(0));
    @(negedge clk);
    check({tag, " rsp0_valid"}, (W+1)'(rsp0_valid), (W+1)'(v.port == 0));
    check({tag, " rsp1_valid"}, (W+1)'(rsp1_valid), (W+1)'(v.port == 1));
    check({tag, " result"}, {rsp_cout, rsp_sum}, {v.cout, v.sum});
    if (v.port == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    check({tag, " done rspv"}, (W+1)'({rsp1_valid, rsp0_valid}), (W+1)'(0));
    check({tag, " done busy"}, (W+1)'(busy), (W+1)'(0));
    check({tag, " err"}, (W+1)'(err), (W+1)'(0));
  endtask

  initial begin
    vecs[0] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1};
    vecs[1] = '{1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 64'h1, 1'b1};
    vecs[2] = '{0, 64'd5, 64'd3, 1'b1, 64'd9, 1'b0};
    vecs[3] = '{1, 64'd10, 64'd20, 1'b0, 64'd30, 1'b0};
    vecs[4] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[5] = '{1, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 64'h1234_5678_9ABC_DF00, 1'b0};
    vecs[6] = '{1, 64'h0000_0000_0000_FFFF, 64'h0, 1'b1, 64'h0000_0000_0001_0000, 1'b0};

    // Reset state
    #2;
    check("reset rspv", (W+1)'({rsp1_valid, rsp0_valid}), (W+1)'(0));
    check("reset result", {rsp_cout, rsp_sum}, '0);
    check("reset busy", (W+1)'(busy), (W+1)'(0));
    check("reset err", (W+1)'(err), (W+1)'(0));
    check("reset ready", (W+1)'({req1_ready, req0_ready}), (W+1)'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) do_op(vecs[i], $sformatf("vec%0d", i));

    // Response stall on requester 1 with requester 0 waiting
    set_req(1, 64'd100, 64'd23, 1'b1);
    #1 check("stall ready1", (W+1)'(req1_ready), (W+1)'(1));
    @(negedge clk);
    req1_valid = 1'b0;
    set_req(0, 64'h40, 64'h2, 1'b0);
    #1 check("stall exec ready0", (W+1)'(req0_ready), (W+1)'(0));
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      check($sformatf("stall%0d rsp1_valid", s), (W+1)'(rsp1_valid), (W+1)'(1));
      check($sformatf("stall%0d result", s), {rsp_cout, rsp_sum}, (W+1)'(124));
      check($sformatf("stall%0d busy", s), (W+1)'(busy), (W+1)'(1));
      check($sformatf("stall%0d ready0", s), (W+1)'(req0_ready), (W+1)'(0));
      @(negedge clk);
    end
    rsp1_ready = 1'b1;
    check("stall release valid", (W+1)'(rsp1_valid), (W+1)'(1));
    @(negedge clk);
    rsp1_ready = 1'b0;
    check("post-stall rsp1_valid", (W+1)'(rsp1_valid), (W+1)'(0));
    check("post-stall ready0", (W+1)'(req0_ready), (W+1)'(1));
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    check("post-stall rsp0_valid", (W+1)'(rsp0_valid), (W+1)'(1));
    check("post-stall result", {rsp_cout, rsp_sum}, (W+1)'(66));
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;

    // Reset asserted while in EXEC
    set_req(0, 64'd7, 64'd8, 1'b0);
    #1 check("midrst ready0", (W+1)'(req0_ready), (W+1)'(1));
    @(negedge clk);
    req0_valid = 1'b0;
    check("midrst exec busy", (W+1)'(busy), (W+1)'(1));
    #2 rst_n = 1'b0;
    #1;
    check("midrst busy", (W+1)'(busy), (W+1)'(0));
    check("midrst rspv", (W+1)'({rsp1_valid, rsp0_valid}), (W+1)'(0));
    check("midrst result", {rsp_cout, rsp_sum}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("midrst after%0d rspv", c), (W+1)'({rsp1_valid, rsp0_valid}), (W+1)'(0));
      check($sformatf("midrst after%0d busy", c), (W+1)'(busy), (W+1)'(0));
    end

    // Continuous contention: grants alternate starting with requester 0
    set_req(0, 64'd5, 64'd3, 1'b1);
    set_req(1, 64'd10, 64'd20, 1'b0);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int op = 0; op < 4; op++) begin
      #1;
      check($sformatf("cont%0d ready0", op), (W+1)'(req0_ready), (W+1)'(op % 2 == 0));
      check($sformatf("cont%0d ready1", op), (W+1)'(req1_ready), (W+1)'(op % 2 == 1));
      @(negedge clk);
      check($sformatf("cont%0d exec ready", op), (W+1)'({req1_ready, req0_ready}), (W+1)'(0));
      @(negedge clk);
      check($sformatf("cont%0d rspv", op), (W+1)'({rsp1_valid, rsp0_valid}), (op % 2 == 0) ? (W+1)'(1) : (W+1)'(2));
      check($sformatf("cont%0d result", op), {rsp_cout, rsp_sum}, (op % 2 == 0) ? (W+1)'(9) : (W+1)'(30));
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    @(negedge clk);

`ifdef ADDER_CHECK_EN
    // Stuck-at-0 on sum bit 0 with an odd true sum
    force dut.add_sum[0] = 1'b0;
    set_req(0, 64'd5, 64'd3, 1'b1);
    @(negedge clk);
    req0_valid = 1'b0;
    check("fault pre err", (W+1)'(err), (W+1)'(0));
    @(negedge clk);
    check("fault err set", (W+1)'(err), (W+1)'(1));
    release dut.add_sum[0];
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    @(negedge clk);
    check("fault err sticky", (W+1)'(err), (W+1)'(1));
    rst_n = 1'b0;
    #1 check("fault err reset", (W+1)'(err), (W+1)'(0));
    @(negedge clk);
    rst_n = 1'b1;
`else
    check("err tied low", (W+1)'(err), (W+1)'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
